// File: rtl/seq_detector_param.sv
// Serial pattern detector: loadable pattern, overlap control, registered match pulse.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_param #(
    parameter int PAT_WIDTH   = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   w,
    input  logic                   w_valid,
    input  logic [PAT_WIDTH-1:0]   pattern,
    input  logic                   load,
    input  logic                   overlap,
    input  logic                   count_clr,
    output logic                   z,
    output logic [3:0]             fill,
    output logic [COUNT_WIDTH-1:0] match_count
);

    localparam logic [3:0] FULL = 4'(PAT_WIDTH);

    logic [PAT_WIDTH-1:0] r_hist;
    logic [PAT_WIDTH-1:0] r_pat;
    logic [3:0]           r_fill;
    logic                 r_z;

    logic [PAT_WIDTH-1:0] w_hist_nxt;
    logic [3:0]           w_fill_nxt;
    logic                 w_match;

    assign w_hist_nxt = {r_hist[PAT_WIDTH-2:0], w};
    assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 4'd1;
    // A load on the same edge discards the sample, so it can never match.
    assign w_match    = w_valid && !load &&
                        (w_fill_nxt == FULL) && (w_hist_nxt == r_pat);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_pat  <= '1;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else begin
            r_z <= w_match;
            if (load) begin
                r_pat  <= pattern;
                r_hist <= '0;
                r_fill <= '0;
            end else if (w_valid) begin
                r_hist <= w_hist_nxt;
                r_fill <= (w_match && !overlap) ? 4'd0 : w_fill_nxt;
            end
        end
    end

    assign z    = r_z;
    assign fill = r_fill;

`ifdef SEQDET_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (count_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_count = r_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = count_clr;
    assign match_count  = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_WIDTH, default 4: pattern length in bits; legal range 2..8.
REQ-002 SHALL have parameter COUNT_WIDTH, default 8: width of the match counter.
REQ-003 SHALL have port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port w, input, 1: serial data bit.
REQ-006 SHALL have port w_valid, input, 1: w is sampled only on edges where this is 1.
REQ-007 SHALL have port pattern, input, PAT_WIDTH: target sequence; MSB is the oldest bit.
REQ-008 SHALL have port load, input, 1: captures pattern into the internal pattern register.
REQ-009 SHALL have port overlap, input, 1: 1 allows overlapping matches; 0 disallows them.
REQ-010 SHALL have port count_clr, input, 1: synchronous clear of match_count.
REQ-011 SHALL have port z, output, 1: registered one-cycle match pulse.
REQ-012 SHALL have port fill, output, 4: number of valid history bits, 0..PAT_WIDTH.
REQ-013 SHALL have port match_count, output, COUNT_WIDTH: saturating count of matches.

Function
REQ-014 SHALL hold a PAT_WIDTH-bit history shift register, a pattern register and a fill counter.
REQ-015 On an edge with w_valid=1 and load=0, history SHALL shift left with w entering at the LSB, and fill SHALL increment, saturating at PAT_WIDTH.
REQ-016 On an edge with w_valid=0, history and fill SHALL hold, and z SHALL be 0 in the next cycle.
REQ-017 A match SHALL occur on an edge where a sample is accepted, the updated fill equals PAT_WIDTH, and the updated history equals the pattern register.
REQ-018 z SHALL be 1 for exactly the one cycle following a matching edge; z is never combinational from w.
REQ-019 With overlap=1, a match SHALL leave fill at PAT_WIDTH, so the next sample can produce another match.
REQ-020 With overlap=0, a match SHALL set fill to 0, so PAT_WIDTH new samples are needed before the next match.
REQ-021 overlap SHALL be evaluated on each matching edge; changing it takes effect on the next match.
REQ-022 load=1 SHALL capture pattern, clear history and fill to 0, and force z to 0 next cycle; a simultaneous w_valid sample is discarded.
REQ-023 match_count SHALL increment on each match, saturating at 2^COUNT_WIDTH-1.
REQ-024 When count_clr and a match coincide, match_count SHALL become 0 (clear wins).
REQ-025 load SHALL NOT affect match_count.

Reset
REQ-026 While reset=1, the block SHALL asynchronously set z=0, fill=0, history=0, match_count=0, and the pattern register to all-ones.
REQ-027 reset SHALL abort any partial match; after reset releases, detection SHALL restart from fill=0.

Configuration
REQ-028 Macro SEQDET_COUNT_EN: when defined, match_count and its logic SHALL be implemented per REQ-023..025.
REQ-029 When SEQDET_COUNT_EN is not defined, match_count SHALL be constant 0, count_clr SHALL be ignored, and no counter flops SHALL be inferred.

Verification (PAT_WIDTH=4, COUNT_WIDTH=8, SEQDET_COUNT_EN defined)
REQ-030 Load pattern 4'b1101, overlap=1, feed 1,1,0,1,1,0,1 with w_valid=1 -> z pulses after the 4th and 7th samples; match_count=2.
REQ-031 Same stream with overlap=0 -> z pulses after the 4th sample only; fill reads 0,1,2,3 after samples 4..7; match_count=1.
REQ-032 Pattern 1101, feed 1,1,0 then hold w_valid=0 for 5 cycles with w=1, then feed 1 -> no z while stalled; z pulses once after the final 1.
REQ-033 Pattern 1111, overlap=1, feed 260 ones -> match_count saturates at 255; z pulses every cycle from the 4th sample onward.
REQ-034 Feed 1,1,0 toward 1101, then pulse load with a new pattern 0000 alongside w_valid=1 -> fill=0, the sample is discarded, and 0,0,0,0 then yields z.
REQ-035 Assert reset mid-stream at a non-edge time -> z, fill, match_count go to 0 immediately; after release, pattern=1111 and no match until four 1s are fed.
